// File: rtl/associative_memory_trainer_pkg.sv
// Shared defaults, trainer state encoding and width helper for the
// associative-memory trainer.
`default_nettype none

package associative_memory_trainer_pkg;

  localparam int DEF_HV_DIMENSION = 8;
  localparam int DEF_CLASSES      = 3;
  localparam int DEF_LABEL_WIDTH  = 2;
  localparam int DEF_COUNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2,
    ST_CLEAR = 2'd3
  } trainer_state_t;

  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/am_bundle_counter.sv
// Saturating signed +/-1 bundle counter; Sign_SO reports value > 0.
`default_nettype none

module am_bundle_counter #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic Clk_CI,
  input  logic Reset_RBI,
  input  logic Enable_SI,
  input  logic Up_SI,
  input  logic Clear_SI,
  output logic Sign_SO
);

  // Symmetric range: the most negative code is never reached.
  localparam logic signed [COUNT_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] CNT_MIN = -CNT_MAX;

  logic signed [COUNT_WIDTH-1:0] value;

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      value <= '0;
    end else if (Clear_SI) begin
      value <= '0;
    end else if (Enable_SI) begin
      if (Up_SI) begin
        if (value != CNT_MAX) value <= value + COUNT_WIDTH'(1);
      end else begin
        if (value != CNT_MIN) value <= value - COUNT_WIDTH'(1);
      end
    end
  end

  assign Sign_SO = !value[COUNT_WIDTH-1] && (value != '0);

endmodule

`default_nettype wire

// File: rtl/associative_memory_trainer.sv
// Bundles labelled hypervectors per class and streams out one
// majority-thresholded prototype per class on request.
`default_nettype none

module associative_memory_trainer
  import associative_memory_trainer_pkg::*;
#(
  parameter int HV_DIMENSION = DEF_HV_DIMENSION,
  parameter int CLASSES      = DEF_CLASSES,
  parameter int LABEL_WIDTH  = DEF_LABEL_WIDTH,
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
  input  logic                    TrainDone_SI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] PrototypeOut_DO,
  output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
  output logic                    LastOut_SO
);

  localparam int CNT_WIDTH = (ceil_log2(CLASSES) > 0) ? ceil_log2(CLASSES) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLASSES - 1);

  trainer_state_t               state;
  trainer_state_t               state_next;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [0:HV_DIMENSION-1]      hv_q;
  logic [LABEL_WIDTH-1:0]       label_q;
  logic                         is_last;
  logic                         out_fire;
  logic [CLASSES*HV_DIMENSION-1:0] signs;
  logic [0:HV_DIMENSION-1]      proto_row;

  assign is_last  = (cnt == LAST_CNT);
  assign out_fire = (state == ST_EMIT) && ReadyIn_SI;

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ValidIn_SI)        state_next = ST_ACCUM;
        else if (TrainDone_SI) state_next = ST_EMIT;
      end
      ST_ACCUM: state_next = ST_IDLE;
      ST_EMIT:  if (out_fire && is_last) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ReadyOut_SO     = (state == ST_IDLE);
    ValidOut_SO     = (state == ST_EMIT);
    LastOut_SO      = (state == ST_EMIT) && is_last;
    LabelOut_DO     = (state == ST_EMIT) ? LABEL_WIDTH'(cnt) : '0;
    PrototypeOut_DO = (state == ST_EMIT) ? proto_row : '0;
  end

  // Sample capture and class counter.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      cnt     <= '0;
      hv_q    <= '0;
      label_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ValidIn_SI) begin
            hv_q    <= HypervectorIn_DI;
            label_q <= LabelIn_DI;
          end else if (TrainDone_SI) begin
            cnt <= '0;
          end
        end
        ST_EMIT:  if (out_fire && !is_last) cnt <= cnt + CNT_WIDTH'(1);
        ST_CLEAR: cnt <= '0;
        default:  ;
      endcase
    end
  end

  always_comb begin
    proto_row = '0;
    for (int c = 0; c < CLASSES; c++) begin
      if (cnt == CNT_WIDTH'(c)) begin
        for (int i = 0; i < HV_DIMENSION; i++) proto_row[i] = signs[c*HV_DIMENSION + i];
      end
    end
  end

  // Out-of-range labels match no row, so they leave every counter untouched.
  generate
    for (genvar c = 0; c < CLASSES; c++) begin : g_class
      logic row_hit;
      assign row_hit = (state == ST_ACCUM) && (label_q == LABEL_WIDTH'(c));
      for (genvar i = 0; i < HV_DIMENSION; i++) begin : g_bit
        am_bundle_counter #(
          .COUNT_WIDTH (COUNT_WIDTH)
        ) u_counter (
          .Clk_CI    (Clk_CI),
          .Reset_RBI (Reset_RBI),
          .Enable_SI (row_hit),
          .Up_SI     (hv_q[i]),
          .Clear_SI  (state == ST_CLEAR),
          .Sign_SO   (signs[c*HV_DIMENSION + i])
        );
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_associative_memory_trainer.sv
// Directed and randomized bench for associative_memory_trainer against a
// per-class integer accumulator model.
`default_nettype none

module tb_associative_memory_trainer;

  localparam int HV  = 8;
  localparam int NC  = 3;
  localparam int LW  = 2;
  localparam int CW  = 4;
  localparam int LIM = 7;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic          ready_out;
  logic [0:HV-1] hv_in;
  logic [LW-1:0] label_in;
  logic          train_done;
  logic          valid_out;
  logic          ready_in;
  logic [0:HV-1] proto_out;
  logic [LW-1:0] label_out;
  logic          last_out;

  int tests_run;
  int tests_failed;
  int acc [NC][HV];

  associative_memory_trainer #(
    .HV_DIMENSION (HV),
    .CLASSES      (NC),
    .LABEL_WIDTH  (LW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .Clk_CI           (clk),
    .Reset_RBI        (rst_n),
    .ValidIn_SI       (valid_in),
    .ReadyOut_SO      (ready_out),
    .HypervectorIn_DI (hv_in),
    .LabelIn_DI       (label_in),
    .TrainDone_SI     (train_done),
    .ValidOut_SO      (valid_out),
    .ReadyIn_SI       (ready_in),
    .PrototypeOut_DO  (proto_out),
    .LabelOut_DO      (label_out),
    .LastOut_SO       (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < HV; i++) acc[c][i] = 0;
  endtask

  task automatic model_apply(input logic [0:HV-1] hv, input int lab);
    if (lab < NC) begin
      for (int i = 0; i < HV; i++) begin
        acc[lab][i] += hv[i] ? 1 : -1;
        if (acc[lab][i] > LIM)  acc[lab][i] = LIM;
        if (acc[lab][i] < -LIM) acc[lab][i] = -LIM;
      end
    end
  endtask

  function automatic logic [0:HV-1] model_proto(input int c);
    logic [0:HV-1] p;
    for (int i = 0; i < HV; i++) p[i] = (acc[c][i] > 0);
    return p;
  endfunction

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    while (ready_out !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk(tag, 32'(ready_out), 32'd1);
  endtask

  task automatic send_sample(input logic [0:HV-1] hv, input int lab);
    wait_idle("sample_wait_ready");
    valid_in = 1'b1;
    hv_in    = hv;
    label_in = LW'(lab);
    @(negedge clk);
    valid_in = 1'b0;
    chk("accum_ready_low", 32'(ready_out), 32'd0);
    model_apply(hv, lab);
  endtask

  task automatic emit_check(input int stall_class);
    logic [0:HV-1] held_proto;
    wait_idle("emit_wait_ready");
    train_done = 1'b1;
    @(negedge clk);
    train_done = 1'b0;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("emit_valid_%0d", c), 32'(valid_out), 32'd1);
      chk($sformatf("emit_label_%0d", c), 32'(label_out), 32'(c));
      chk($sformatf("emit_last_%0d", c), 32'(last_out), 32'(c == NC - 1));
      chk($sformatf("emit_proto_%0d", c), 32'(proto_out), 32'(model_proto(c)));
      if (c == stall_class) begin
        held_proto = model_proto(c);
        ready_in = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 32'(valid_out), 32'd1);
          chk("stall_label", 32'(label_out), 32'(c));
          chk("stall_proto", 32'(proto_out), 32'(held_proto));
        end
        ready_in = 1'b1;
      end
      @(negedge clk);
    end
    chk("clear_valid_low", 32'(valid_out), 32'd0);
    chk("clear_ready_low", 32'(ready_out), 32'd0);
    model_clear();
    @(negedge clk);
    chk("post_clear_ready", 32'(ready_out), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    valid_in     = 1'b0;
    hv_in        = '0;
    label_in     = '0;
    train_done   = 1'b0;
    ready_in     = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);

    chk("reset_ready", 32'(ready_out), 32'd1);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_last",  32'(last_out),  32'd0);
    chk("reset_label", 32'(label_out), 32'd0);
    chk("reset_proto", 32'(proto_out), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);

    send_sample(8'b11110000, 1);
    send_sample(8'b11001100, 1);
    send_sample(8'b10101010, 1);
    emit_check(-1);

    send_sample(8'hFF, 0);
    send_sample(8'h00, 0);
    emit_check(-1);

    repeat (10) send_sample(8'hFF, 2);
    repeat (8)  send_sample(8'h00, 2);
    emit_check(-1);

    send_sample(8'($urandom), 1);
    send_sample(8'($urandom), 1);
    send_sample(8'($urandom), 0);
    emit_check(1);
    emit_check(-1);

    send_sample(8'hAA, 0);
    send_sample(8'h3C, 2);
    send_sample(8'hFF, 3);
    emit_check(-1);

    // Sample and train-done together: the sample wins.
    wait_idle("prio_wait_ready");
    valid_in   = 1'b1;
    train_done = 1'b1;
    hv_in      = 8'hF0;
    label_in   = 2'd0;
    @(negedge clk);
    valid_in   = 1'b0;
    train_done = 1'b0;
    chk("prio_no_emit", 32'(valid_out), 32'd0);
    chk("prio_accum",   32'(ready_out), 32'd0);
    model_apply(8'hF0, 0);
    @(negedge clk);
    chk("prio_idle_valid", 32'(valid_out), 32'd0);
    emit_check(-1);

    for (int round = 0; round < 4; round++) begin
      int n;
      n = 10 + $urandom_range(0, 30);
      for (int k = 0; k < n; k++) send_sample(8'($urandom), $urandom_range(0, 3));
      emit_check((round == 2) ? 0 : -1);
    end

    send_sample(8'hFF, 0);
    send_sample(8'hFF, 2);
    wait_idle("rst_wait_ready");
    train_done = 1'b1;
    @(negedge clk);
    train_done = 1'b0;
    chk("rst_pre_valid", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid_low", 32'(valid_out), 32'd0);
    chk("rst_ready_high", 32'(ready_out), 32'd1);
    chk("rst_last_low", 32'(last_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    emit_check(-1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/associative_memory_trainer.md
# associative_memory_trainer

Training-side counterpart of the associative-memory classifier: accepts labelled query hypervectors, bundles them per class into saturating bipolar bit accumulators, and on request streams out one majority-thresholded prototype hypervector per class. It sits between the encoder and the classifier's prototype load path.

## Interface
- `HV_DIMENSION`, default `` `HV_DIMENSION ``: hypervector width in bits.
- `CLASSES`, default `` `CLASSES ``: number of classes.
- `LABEL_WIDTH`, default `` `LABEL_WIDTH ``: label field width.
- `COUNT_WIDTH`, default 8: signed accumulator width per bit.

- `Clk_CI`, in, 1: clock.
- `Reset_RBI`, in, 1: reset, asynchronous, active-low.
- `ValidIn_SI`, in, 1: sample valid.
- `ReadyOut_SO`, out, 1: sample ready.
- `HypervectorIn_DI`, in, [0:HV_DIMENSION-1]: training hypervector.
- `LabelIn_DI`, in, LABEL_WIDTH: class of the sample.
- `TrainDone_SI`, in, 1: level request to emit prototypes.
- `ValidOut_SO`, out, 1: prototype valid.
- `ReadyIn_SI`, in, 1: downstream ready.
- `PrototypeOut_DO`, out, [0:HV_DIMENSION-1]: thresholded prototype.
- `LabelOut_DO`, out, LABEL_WIDTH: class index of the prototype.
- `LastOut_SO`, out, 1: high with the prototype for class CLASSES-1.

## Operation
- Storage: CLASSES×HV_DIMENSION signed accumulators. Range is symmetric: ±(2^(COUNT_WIDTH-1)-1).
- Accumulate: each input bit 1 adds +1 and each bit 0 adds −1 to the row `LabelIn_DI`. Both directions saturate, so the value never reaches −2^(COUNT_WIDTH-1).
- Threshold: a prototype bit is 1 iff its accumulator is greater than 0. Ties (0) give 0.
- Labels ≥ CLASSES complete the handshake normally and are discarded; no accumulator changes.
- FSM states:
  - IDLE: `ReadyOut_SO`=1.
    - `ValidIn_SI`=1: capture the hypervector and label, go to ACCUM.
    - Else if `TrainDone_SI`=1: go to EMIT with the class counter at 0.
    - A sample has priority over `TrainDone_SI` in the same cycle.
  - ACCUM: update the captured row, go to IDLE. `ReadyOut_SO`=0.
  - EMIT: `ValidOut_SO`=1.
    - `PrototypeOut_DO` is the threshold of row cnt, `LabelOut_DO`=cnt, `LastOut_SO`=(cnt==CLASSES-1).
    - On `ValidOut_SO`&&`ReadyIn_SI`: if last, go to CLEAR; else cnt+1.
  - CLEAR: zero all accumulators, go to IDLE.
- Outputs stay stable while `ValidOut_SO`=1 and `ReadyIn_SI`=0.
- Reset values: state IDLE, all accumulators 0, cnt 0.
  - `ReadyOut_SO`=1, `ValidOut_SO`=0, `LastOut_SO`=0 (gated by EMIT), `LabelOut_DO`=0, `PrototypeOut_DO`=all 0.
- Reset asserted mid-EMIT or mid-ACCUM: immediately returns to the reset state. Partial training is lost.

## Timing
- Sample handshake at edge t → row updated at edge t+1 → `ReadyOut_SO`=1 again in cycle t+2. Maximum throughput is 1 sample per 2 cycles.
- `TrainDone_SI` sampled in IDLE at edge t → first prototype valid in cycle t+1.
- With `ReadyIn_SI` tied high, one prototype per cycle; the EMIT phase lasts CLASSES cycles.
- Final handshake at edge t → CLEAR in cycle t+1 → IDLE with `ReadyOut_SO`=1 in cycle t+2.
- `PrototypeOut_DO` is combinational from the accumulators and cnt. There is no extra latency.

## Structure
- `const.vh` holds:
  - `HV_DIMENSION`, `CLASSES`, `LABEL_WIDTH`, `ceilLog2`.
  - The trainer state encodings (IDLE, ACCUM, EMIT, CLEAR).
  - The default COUNT_WIDTH.
- One sub-module, `am_bundle_counter`: a single saturating signed ±1 counter with enable and synchronous clear. It outputs `Sign_SO` (value>0) and is instantiated per bit per class.
- Class counter width: `ceilLog2(CLASSES)`.

## Test plan
Parameters for all scenarios: HV_DIMENSION=8, CLASSES=3, COUNT_WIDTH=4 (range ±7).
- Reset → `ReadyOut_SO`=1, `ValidOut_SO`=0, `LastOut_SO`=0, `LabelOut_DO`=0, `PrototypeOut_DO`=8'h00.
- Class-1 samples 8'b11110000, 8'b11001100, 8'b10101010, then `TrainDone_SI` → prototypes emitted in order:
  - label 0: 8'h00;
  - label 1: 8'b11101000;
  - label 2: 8'h00 with `LastOut_SO`=1.
- Tie case: class 0 receives 8'hFF then 8'h00 → emitted class 0 is 8'h00.
- Saturation case: class 2 receives 10× 8'hFF, then 8× 8'h00 → class 2 is 8'h00 (without saturation it would be 8'hFF).
- Backpressure and clear:
  - Hold `ReadyIn_SI`=0 for 5 cycles on label 1 → outputs held unchanged.
  - After the last handshake, `ReadyOut_SO`=1 two cycles later.
  - A second `TrainDone_SI` emits all-zero prototypes.
- Label 3 sample is accepted and ignored (all prototypes unchanged).
- `Reset_RBI` pulsed low mid-EMIT → `ValidOut_SO`=0 immediately, then IDLE with cleared accumulators.
